// File: rtl/apb_master_bridge_if.sv
// Host request/response port plus APB requester signals for apb_master_bridge.
interface apb_master_bridge_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              cs;
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              slverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, slverr,
        output req_ready, resp_valid, resp_rdata, resp_err,
               cs, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, slverr,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               cs, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: host valid/ready in, SETUP/ACCESS out,
// one-cycle response strobe with slave error or timeout.
module apb_master_bridge #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned SEL_LSB = 6,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_master_bridge_if.master  bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             ready_qual;

    assign bus.req_ready = (state == IDLE) && !PRESETn;
    assign accept        = bus.req_valid && bus.req_ready;
    // The first ACCESS cycle may still see the previous transfer's PREADY.
    assign ready_qual    = bus.PREADY && (wait_cnt != '0);

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.cs         <= 1'b0;
            bus.PSEL1      <= 1'b0;
            bus.PSEL2      <= 1'b0;
            bus.PENABLE    <= 1'b0;
            bus.PWRITE     <= 1'b0;
            bus.PADDR      <= '0;
            bus.PWDATA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.resp_valid <= 1'b0;
                    if (accept) begin
                        bus.cs      <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        bus.PSEL1   <= bus.req_addr[SEL_LSB];
                        bus.PSEL2   <= bus.req_addr[SEL_LSB+1];
                        bus.PWRITE  <= bus.req_write;
                        bus.PADDR   <= ADDR_W'(bus.req_addr[SEL_LSB-1:0]);
                        bus.PWDATA  <= bus.req_wdata;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    if (ready_qual) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= bus.slverr;
                        bus.resp_rdata <= (!bus.PWRITE && !bus.slverr) ? bus.PRDATA : '0;
                        bus.cs         <= 1'b0;
                        bus.PENABLE    <= 1'b0;
                        state          <= IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // No slave answered in time: report an error with zero data.
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                        bus.cs         <= 1'b0;
                        bus.PENABLE    <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, randomized
// transfers against a reference model, reset and streaming sequences.
module tb_apb_master_bridge;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned SEL_LSB = 6;
    localparam int unsigned TIMEOUT = 16;
    localparam int          TO_LAT  = TIMEOUT + 1;

    logic PCLK;
    logic PRESETn;

    apb_master_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    apb_master_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .bus(bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic logic [63:0] pat(input int i);
        return {32'(i) * 32'h9E37_79B9, 32'hC0DE_0000 | 32'(i)};
    endfunction

    // Slave bank: only index 0 is populated; registered PREADY that keeps its
    // last value while not addressed, with a programmable wait and error.
    logic [63:0] slave_mem [64];
    logic        s0_ready, s0_err;
    logic [63:0] s0_rdata;
    int          s_wcnt;
    int          s_wait;
    logic        s_err_knob;
    logic        sel0;

    assign sel0        = !bus.PSEL1 && !bus.PSEL2;
    assign bus.PREADY  = sel0 ? s0_ready : 1'b0;
    assign bus.PRDATA  = sel0 ? s0_rdata : 64'hFFFF_0000_DEAD_0000;
    assign bus.slverr  = sel0 ? s0_err : 1'b1;

    always @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            s0_ready <= 1'b0;
            s0_err   <= 1'b0;
            s0_rdata <= '0;
            s_wcnt   <= 0;
            for (int i = 0; i < 64; i++) slave_mem[i] <= pat(i);
        end else if (bus.cs && bus.PENABLE && sel0) begin
            if (s_wcnt >= s_wait) begin
                s0_ready <= 1'b1;
                s0_err   <= s_err_knob;
                if (bus.PWRITE) s0_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
                else            s0_rdata <= s_err_knob ? ~slave_mem[bus.PADDR[5:0]]
                                                       : slave_mem[bus.PADDR[5:0]];
                if (bus.PWRITE && !s_err_knob) slave_mem[bus.PADDR[5:0]] <= bus.PWDATA;
            end else begin
                s0_ready <= 1'b0;
                s_wcnt   <= s_wcnt + 1;
            end
        end else begin
            s_wcnt <= 0;
        end
    end

    // Reference model of the populated slave's storage.
    logic [63:0] ref_mem [64];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One host transfer with bus-level checks while the transfer is in flight.
    task automatic do_txn(input string nm, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input int w, input logic e,
                          input logic exp_err, input logic [63:0] exp_rdata,
                          input int exp_lat);
        int          n;
        int          lat;
        int          apb_bad;
        logic        got;
        logic [1:0]  exp_sel;
        logic [63:0] exp_paddr;
        s_wait         = w;
        s_err_knob     = e;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (!bus.req_ready) begin
            chk({nm, "_accept_timeout"}, 64'(bus.req_ready), 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge PCLK); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        bus.req_write = ~wr;
        exp_sel   = addr[7:6];
        exp_paddr = {58'h0, addr[5:0]};
        apb_bad = 0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (bus.cs !== 1'b1 || {bus.PSEL2, bus.PSEL1} !== exp_sel ||
                bus.PADDR !== exp_paddr || bus.PWRITE !== wr || bus.PWDATA !== wdata ||
                bus.PENABLE !== (lat >= 1) || bus.req_ready !== 1'b0 ||
                bus.resp_valid !== 1'b0)
                apb_bad++;
            @(posedge PCLK); #1;
            lat++;
            if (bus.resp_valid === 1'b1) got = 1'b1;
        end
        chk({nm, "_apb"}, 64'(apb_bad), 64'd0);
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_err"}, 64'(bus.resp_err), 64'(exp_err));
        chk({nm, "_rdata"}, bus.resp_rdata, exp_rdata);
        chk({nm, "_busidle"}, {62'h0, bus.cs, bus.PENABLE}, 64'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          w;
        logic        e;
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [63:0] a, d, er;
        logic        wr, e, xe;
        int          w, xl;
        logic [63:0] dq [4];
        int          k, rises, gap_bad, order_bad;
        logic        acc, cs_b;

        tbl[0]  = '{1'b1, 64'h05, 64'hDEADBEEF_CAFEF00D, 0, 1'b0, 1'b0, 64'h0, 3};
        tbl[1]  = '{1'b0, 64'h05, 64'h0, 0, 1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D, 3};
        tbl[2]  = '{1'b0, 64'h45, 64'h0, 0, 1'b0, 1'b1, 64'h0, TO_LAT};
        tbl[3]  = '{1'b0, 64'h05, 64'h0, 0, 1'b1, 1'b1, 64'h0, 3};
        tbl[4]  = '{1'b1, 64'h0A, 64'h0123_4567_89AB_CDEF, 2, 1'b0, 1'b0, 64'h0, 5};
        tbl[5]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FF0A, 64'h0, 4, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 7};
        tbl[6]  = '{1'b0, 64'h85, 64'h0, 0, 1'b0, 1'b1, 64'h0, TO_LAT};
        tbl[7]  = '{1'b0, 64'h0A, 64'h0, 14, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, TO_LAT};
        tbl[8]  = '{1'b0, 64'h0A, 64'h0, 30, 1'b0, 1'b1, 64'h0, TO_LAT};
        tbl[9]  = '{1'b1, 64'hC3, 64'h55, 0, 1'b0, 1'b1, 64'h0, TO_LAT};
        tbl[10] = '{1'b1, 64'h05, 64'h1111, 1, 1'b1, 1'b1, 64'h0, 4};
        tbl[11] = '{1'b0, 64'h05, 64'h0, 0, 1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D, 3};

        PRESETn       = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        s_wait        = 0;
        s_err_knob    = 1'b0;

        // Reset state, then an asynchronous reset in the middle of ACCESS.
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_ctrl", {58'h0, bus.cs, bus.PENABLE, bus.PSEL2, bus.PSEL1, bus.PWRITE,
                         bus.resp_valid}, 64'd0);
        chk("rst_paddr", bus.PADDR, 64'd0);
        chk("rst_pwdata", bus.PWDATA, 64'd0);
        chk("rst_resp", {bus.resp_rdata[62:0], bus.resp_err} | {63'h0, bus.resp_rdata[63]}, 64'd0);
        PRESETn = 1'b0;
        #1;
        chk("rel_req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_addr  = 64'h45;
        bus.req_valid = 1'b1;
        @(posedge PCLK); #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge PCLK);
        #3;
        chk("pre_rst_access", {62'h0, bus.cs, bus.PENABLE}, 64'd3);
        PRESETn = 1'b1;
        #1;
        chk("async_rst_ctrl", {60'h0, bus.cs, bus.PENABLE, bus.resp_valid, bus.req_ready}, 64'd0);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("async_rel_ready", 64'(bus.req_ready), 64'd1);
        @(posedge PCLK); #1;
        chk("async_rel_idle", {62'h0, bus.cs, bus.req_ready}, 64'd1);
        for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);

        // Directed vectors, issued back to back in each response cycle.
        for (int i = 0; i < 12; i++) begin
            do_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].w,
                   tbl[i].e, tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_lat);
            a = tbl[i].addr;
            if (tbl[i].wr && !tbl[i].exp_err) ref_mem[a[5:0]] = tbl[i].wdata;
        end
        @(posedge PCLK); #1;
        chk("resp_one_cycle", 64'(bus.resp_valid), 64'd0);

        // Randomized transfers against the reference model.
        for (int i = 0; i < 120; i++) begin
            wr = 1'($urandom);
            a  = {$urandom, $urandom};
            a[7:6] = ($urandom % 4 == 0) ? 2'(1 + $urandom % 3) : 2'b00;
            d  = {$urandom, $urandom};
            w  = $urandom % 6;
            e  = ($urandom % 8 == 0);
            if (a[7:6] != 2'b00 || w + 3 > TO_LAT) begin
                xe = 1'b1; er = 64'h0; xl = TO_LAT;
            end else begin
                xe = e;
                er = (!wr && !e) ? ref_mem[a[5:0]] : 64'h0;
                xl = w + 3;
                if (wr && !e) ref_mem[a[5:0]] = d;
            end
            do_txn($sformatf("rnd%0d", i), wr, a, d, w, e, xe, er, xl);
            repeat ($urandom % 3) @(posedge PCLK);
            #0;
        end

        // Streaming writes with req_valid held high.
        for (int i = 0; i < 4; i++) dq[i] = {$urandom, $urandom};
        s_wait = 0; s_err_knob = 1'b0;
        k = 0; rises = 0; gap_bad = 0; order_bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (k < 4) begin
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_addr  = 64'h20 + 64'(k);
                bus.req_wdata = dq[k];
            end else begin
                bus.req_valid = 1'b0;
            end
            acc  = bus.req_valid && bus.req_ready;
            cs_b = bus.cs;
            @(posedge PCLK); #1;
            if (bus.cs && !cs_b) begin
                rises++;
                if (rises > 4 || bus.PWDATA !== dq[rises-1]) order_bad++;
            end
            if (acc) begin
                if (cs_b) gap_bad++;
                k++;
            end
        end
        chk("stream_accepts", 64'(rises), 64'd4);
        chk("stream_gap", 64'(gap_bad), 64'd0);
        chk("stream_order", 64'(order_bad), 64'd0);
        for (int i = 0; i < 4; i++) ref_mem[32 + i] = dq[i];
        for (int i = 0; i < 4; i++) begin
            a = 64'h20 + 64'(i);
            do_txn($sformatf("stream_rd%0d", i), 1'b0, a, 64'h0, 0, 1'b0, 1'b0,
                   ref_mem[a[5:0]], 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
